// File: rtl/mem_access_pkg.sv
// Shared types, masks and RV32I funct3 encodings for the memory-access stage.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } mem_state_t;

    localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Size lives in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3)
            F3_SB:   s = 4'b0001 << a;
            F3_SH:   s = 4'b0011 << a;
            F3_SW:   s = 4'b1111;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            F3_SB:   w = {4{d[7:0]}};
            F3_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// req/gnt/rvalid data bus between the memory stage and the memory system.
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_load_align.sv
// Combinational load aligner: selects byte/half by address and produces the write-back mask.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data,
    output logic [31:0] wb_mask
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    // Unsigned loads keep stale upper bits; write_back clears them with the mask.
    always_comb begin
        read_data = shifted;
        wb_mask   = MASK_WORD;
        case (funct3)
            F3_LB:   read_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   read_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   read_data = rdata;
            F3_LBU:  wb_mask   = MASK_BYTE;
            F3_LHU:  wb_mask   = MASK_HALF;
            default: read_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: drives the req/gnt/rvalid bus for loads/stores, aligns load data,
// flags misaligned accesses and bus timeouts.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  mem_op_t      mem_op,
    input  logic [2:0]   funct3,
    input  logic [31:0]  addr,
    input  logic [31:0]  store_data,
    mem_access_if.master bus,
    output logic         out_valid,
    output logic [31:0]  read_data,
    output logic [31:0]  wb_mask,
    output logic         misaligned,
    output logic         bus_error
);

    localparam int unsigned   CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    mem_state_t    state, state_n;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    addr_lo_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;

    logic          accept;
    logic          acc_mis;
    logic [31:0]   align_data;
    logic [31:0]   align_mask;
    logic [31:0]   rd_n;
    logic [31:0]   mask_n;
    logic          mis_n;
    logic          err_n;

    assign accept  = in_valid && (state == IDLE);
    assign acc_mis = is_misaligned(funct3, addr[1:0]);

    load_align u_load_align (
        .rdata     (bus.bus_rdata),
        .addr_lo   (addr_lo_q),
        .funct3    (f3_q),
        .read_data (align_data),
        .wb_mask   (align_mask)
    );

    always_comb begin
        state_n = state;
        rd_n    = '0;
        mask_n  = '0;
        mis_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mem_op == MEM_NONE) begin
                        state_n = RESP;
                    end else if (acc_mis) begin
                        state_n = RESP;
                        mis_n   = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.bus_gnt) begin
                    state_n = we_q ? RESP : WAIT;
                end else if (cnt == CNT_MAX) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            WAIT: begin
                if (bus.bus_rvalid) begin
                    state_n = RESP;
                    rd_n    = align_data;
                    mask_n  = align_mask;
                end else if (cnt == CNT_MAX) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == RESP);
    assign bus.bus_req   = (state == REQ);
    assign bus.bus_we    = (state == REQ) && we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_lo_q  <= '0;
            bus_addr_q <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            read_data  <= '0;
            wb_mask    <= '0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state <= state_n;
            // Any state change restarts the count, so REQ and WAIT each get a full budget.
            if (state_n != state) begin
                cnt <= '0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                we_q      <= (mem_op == MEM_STORE);
                f3_q      <= funct3;
                addr_lo_q <= addr[1:0];
            end
            if (accept && state_n == REQ) begin
                bus_addr_q <= {addr[31:2], 2'b00};
                wdata_q    <= store_wdata(funct3, store_data);
                wstrb_q    <= (mem_op == MEM_STORE) ? store_strb(funct3, addr[1:0]) : 4'b0000;
            end
            if (state_n == RESP) begin
                read_data  <= rd_n;
                wb_mask    <= mask_n;
                misaligned <= mis_n;
                bus_error  <= err_n;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed ops push expected responses,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    mem_op_t     mem_op;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        out_valid;
    logic [31:0] read_data;
    logic [31:0] wb_mask;
    logic        misaligned;
    logic        bus_error;

    mem_access_if bus_if ();

    mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_op     (mem_op),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .bus        (bus_if),
        .out_valid  (out_valid),
        .read_data  (read_data),
        .wb_mask    (wb_mask),
        .misaligned (misaligned),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned acc;
        int unsigned lat;   // 0 = latency not checked
        logic [31:0] data;  // expected read_data & wb_mask
        logic [31:0] mask;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.lat != 0) check("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                check("misaligned", 32'(misaligned), 32'(mon_e.mis));
                check("bus_error", 32'(bus_error), 32'(mon_e.err));
                check("wb_mask", wb_mask, mon_e.mask);
                check("masked_data", read_data & wb_mask, mon_e.data);
            end
        end
    end

    // rv_dly < 0 means rvalid is never returned.
    task automatic issue(input mem_op_t op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int gd, input int rv_dly,
                         input logic [31:0] rdata, input logic [3:0] xstrb,
                         input logic [31:0] xwdata, input int unsigned lat,
                         input logic [31:0] xdata, input logic [31:0] xmask,
                         input logic xmis, input logic xerr);
        exp_t e;
        int unsigned reqs;
        int k;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        mem_op     = op;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.acc  = cyc;
        e.lat  = lat;
        e.data = xdata;
        e.mask = xmask;
        e.mis  = xmis;
        e.err  = xerr;
        sb.push_back(e);
        if (op == MEM_NONE || xmis) begin
            @(negedge clk);
            check("no_bus_req", 32'(bus_if.bus_req), 32'd0);
        end else begin
            reqs = 0;
            for (int i = 0; i <= gd; i++) begin
                bus_if.bus_gnt = (i == gd);
                @(negedge clk);
                if (bus_if.bus_req === 1'b1) reqs++;
                check("bus_addr", bus_if.bus_addr, {a[31:2], 2'b00});
                check("bus_we", 32'(bus_if.bus_we), 32'(op == MEM_STORE));
                if (op == MEM_STORE) begin
                    check("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(xstrb));
                    check("bus_wdata", bus_if.bus_wdata, xwdata);
                end
                @(posedge clk);
                #1;
            end
            bus_if.bus_gnt = 1'b0;
            check("req_cycles", 32'(reqs), 32'(gd + 1));
            if (op == MEM_LOAD && rv_dly >= 0) begin
                for (int j = 0; j <= rv_dly; j++) begin
                    bus_if.bus_rvalid = (j == rv_dly);
                    bus_if.bus_rdata  = (j == rv_dly) ? rdata : 32'h5A5A_5A5A;
                    @(posedge clk);
                    #1;
                end
                bus_if.bus_rvalid = 1'b0;
                bus_if.bus_rdata  = 32'hA5A5_A5A5;
            end
        end
        k = 0;
        while (in_ready !== 1'b1 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 60) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got busy expected idle (cycle %0d)", cyc);
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        in_valid          = 1'b0;
        mem_op            = MEM_NONE;
        funct3            = '0;
        addr              = '0;
        store_data        = '0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_wb_mask", wb_mask, 32'd0);
        check("rst_bus_addr", bus_if.bus_addr, 32'd0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        check("rst_bus_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        check("rst_flags", 32'({misaligned, bus_error}), 32'd0);
        rst = 1'b0;

        //    op         f3      addr           sdata          gd rv  rdata          strb     wdata          lat data           mask           mis   err
        issue(MEM_LOAD,  F3_LW,  32'h0000_0100, 32'h0,         0, 0,  32'hDEAD_BEEF, 4'b0000, 32'h0,         3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(MEM_LOAD,  F3_LB,  32'h0000_0103, 32'h0,         0, 0,  32'h8011_2233, 4'b0000, 32'h0,         3, 32'hFFFF_FF80, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(MEM_LOAD,  F3_LBU, 32'h0000_0103, 32'h0,         0, 0,  32'h8011_2233, 4'b0000, 32'h0,         3, 32'h0000_0080, 32'h0000_00FF, 1'b0, 1'b0);
        issue(MEM_LOAD,  F3_LH,  32'h0000_0102, 32'h0,         1, 2,  32'h8001_1234, 4'b0000, 32'h0,         6, 32'hFFFF_8001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(MEM_LOAD,  F3_LHU, 32'h0000_0102, 32'h0,         0, 0,  32'h8001_1234, 4'b0000, 32'h0,         3, 32'h0000_8001, 32'h0000_FFFF, 1'b0, 1'b0);
        issue(MEM_LOAD,  F3_LH,  32'h0000_0100, 32'h0,         0, 0,  32'h1234_7FFF, 4'b0000, 32'h0,         3, 32'h0000_7FFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(MEM_STORE, F3_SH,  32'h0000_0202, 32'h0000_ABCD, 2, 0,  32'h0,         4'b1100, 32'hABCD_ABCD, 4, 32'h0,         32'h0,         1'b0, 1'b0);
        issue(MEM_STORE, F3_SB,  32'h0000_0201, 32'h1234_56EF, 0, 0,  32'h0,         4'b0010, 32'hEFEF_EFEF, 2, 32'h0,         32'h0,         1'b0, 1'b0);
        issue(MEM_STORE, F3_SW,  32'h0000_0300, 32'hCAFE_F00D, 0, 0,  32'h0,         4'b1111, 32'hCAFE_F00D, 2, 32'h0,         32'h0,         1'b0, 1'b0);
        issue(MEM_LOAD,  F3_LW,  32'h0000_0101, 32'h0,         0, 0,  32'h0,         4'b0000, 32'h0,         1, 32'h0,         32'h0,         1'b1, 1'b0);
        issue(MEM_STORE, F3_SH,  32'h0000_0203, 32'h0000_1111, 0, 0,  32'h0,         4'b0000, 32'h0,         1, 32'h0,         32'h0,         1'b1, 1'b0);
        issue(MEM_NONE,  F3_LW,  32'h0000_0055, 32'h0,         0, 0,  32'h0,         4'b0000, 32'h0,         1, 32'h0,         32'h0,         1'b0, 1'b0);
        issue(MEM_LOAD,  F3_LW,  32'h0000_0400, 32'h0,         0, -1, 32'h0,         4'b0000, 32'h0,         0, 32'h0,         32'h0,         1'b0, 1'b1);

        // Reset while waiting for read data: back to idle, no response, late rvalid discarded.
        @(negedge clk);
        in_valid = 1'b1;
        mem_op   = MEM_LOAD;
        funct3   = F3_LW;
        addr     = 32'h0000_0500;
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        bus_if.bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_gnt = 1'b0;
        check("wait_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_idle", 32'(in_ready), 32'd1);
        check("rst_mid_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        bus_if.bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rvalid_ignored", 32'(out_valid), 32'd0);
        end
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
